// File: rtl/pwm_edge_preconditioner_pkg.sv
// Shared widths and the modulo-by-conditional-subtraction helper for the
// PWM edge preconditioner.
package pwm_pkg;

   localparam int PWM_WIDTH = 13;
   localparam int PWM_DEPTH = 249;
   localparam int PWM_EXT_W = PWM_WIDTH + 2;

   // Exact for value < 3*c, which covers every normalised rise/fall sum.
   function automatic logic [PWM_WIDTH-1:0] edge_mod(input logic [PWM_EXT_W-1:0] value,
                                                     input logic [PWM_WIDTH-1:0] c);
      logic [PWM_EXT_W-1:0] v;
      logic [PWM_EXT_W-1:0] c_e;
      v   = value;
      c_e = {2'b00, c};
      if (c == '0) return '0;
      if (v >= c_e) v = v - c_e;
      if (v >= c_e) v = v - c_e;
      return v[PWM_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/pwm_edge_preconditioner_if.sv
// Serial duty/phase input stream and parallel rise/fall edge register bank.
interface pwm_edge_preconditioner_if #(
   parameter int WIDTH = pwm_pkg::PWM_WIDTH,
   parameter int DEPTH = pwm_pkg::PWM_DEPTH
);
   logic                        DIN_VALID;
   logic [DEPTH-1:0][WIDTH-1:0] CYCLE;
   logic [WIDTH-1:0]            DUTY;
   logic [WIDTH-1:0]            PHASE;
   logic [DEPTH-1:0][WIDTH-1:0] RISE;
   logic [DEPTH-1:0][WIDTH-1:0] FALL;
   logic                        DOUT_VALID;

   modport master (output DIN_VALID, CYCLE, DUTY, PHASE, input RISE, FALL, DOUT_VALID);
   modport slave  (input DIN_VALID, CYCLE, DUTY, PHASE, output RISE, FALL, DOUT_VALID);
endinterface

// File: rtl/pwm_edge_preconditioner_calc.sv
// Per-element arithmetic pipeline: normalise (S1), raw edge sums (S2); the
// modulo reduction feeds the top-level edge registers (S3).
module pwm_edge_calc
   import pwm_pkg::*;
#(
   parameter int WIDTH = pwm_pkg::PWM_WIDTH,
   parameter int IDX_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_index,
   input  logic [WIDTH-1:0] duty,
   input  logic [WIDTH-1:0] phase,
   input  logic [WIDTH-1:0] cycle,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_index,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   localparam int EW = WIDTH + 2;

   logic [WIDTH-1:0] duty_n, phase_n;
   logic             v1, v2;
   logic [IDX_W-1:0] idx1, idx2;
   logic [WIDTH-1:0] d1, p1, c1, c2;
   logic [EW-1:0]    d_e, p_e, c_e, rise_sum, fall_sum, rise_raw, fall_raw;

   always_comb begin
      duty_n  = duty;
      phase_n = phase;
      if (duty > cycle)   duty_n  = cycle;
      if (phase >= cycle) phase_n = phase - cycle;
   end

   always_comb begin
      d_e      = {2'b00, d1};
      p_e      = {2'b00, p1};
      c_e      = {2'b00, c1};
      rise_sum = (c_e << 1) - p_e - (d_e >> 1);
      fall_sum = c_e - p_e + ((d_e + EW'(1)) >> 1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= in_valid;
         v2 <= v1;
      end
   end

   // NOTE: datapath registers carry no reset; only the valid bits qualify them.
   always_ff @(posedge CLK) begin
      idx1     <= in_index;
      d1       <= duty_n;
      p1       <= phase_n;
      c1       <= cycle;
      idx2     <= idx1;
      c2       <= c1;
      rise_raw <= rise_sum;
      fall_raw <= fall_sum;
   end

   assign out_valid = v2;
   assign out_index = idx2;
   assign rise      = edge_mod(rise_raw, c2);
   assign fall      = edge_mod(fall_raw, c2);
endmodule

// File: rtl/pwm_edge_preconditioner.sv
// Top level: transducer index counter, edge register bank write decode and
// the end-of-frame DOUT_VALID pulse.
module pwm_edge_preconditioner
   import pwm_pkg::*;
#(
   parameter int WIDTH = pwm_pkg::PWM_WIDTH,
   parameter int DEPTH = pwm_pkg::PWM_DEPTH
) (
   input logic                     CLK,
   input logic                     RST,
   pwm_edge_preconditioner_if.slave port
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W-1:0] in_index, out_index;
   logic             out_valid;
   logic [WIDTH-1:0] rise, fall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                                  in_index <= '0;
      else if (!port.DIN_VALID || in_index == IDX_W'(DEPTH-1)) in_index <= '0;
      else                                                      in_index <= in_index + 1'b1;
   end

   pwm_edge_calc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_calc (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (port.DIN_VALID),
      .in_index (in_index),
      .duty     (port.DUTY),
      .phase    (port.PHASE),
      .cycle    (port.CYCLE[in_index]),
      .out_valid(out_valid),
      .out_index(out_index),
      .rise     (rise),
      .fall     (fall)
   );

   // NOTE: the edge bank is reset because the PWM timers read every entry
   // continuously; it is a register array, not a RAM.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         port.RISE       <= '0;
         port.FALL       <= '0;
         port.DOUT_VALID <= 1'b0;
      end else begin
         // The last index is only reachable after DEPTH unbroken valid cycles.
         port.DOUT_VALID <= out_valid && (out_index == IDX_W'(DEPTH-1));
         if (out_valid) begin
            port.RISE[out_index] <= rise;
            port.FALL[out_index] <= fall;
         end
      end
   end
endmodule

// File: tb/tb_pwm_edge_preconditioner.sv
// Scoreboard bench: the driver queues each frame's expected edge bank, a
// negedge monitor checks it whenever DOUT_VALID pulses.
module tb_pwm_edge_preconditioner;
   import pwm_pkg::*;

   localparam int W = PWM_WIDTH;
   localparam int N = PWM_DEPTH;
   typedef logic [N-1:0][W-1:0] arr_t;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   pwm_edge_preconditioner_if #(.WIDTH(W), .DEPTH(N)) bus ();

   pwm_edge_preconditioner #(.WIDTH(W), .DEPTH(N)) dut (
      .CLK (CLK),
      .RST (RST),
      .port(bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Stimulus arrays, shadow model and scoreboard queues
   int    fd[N], fp[N];
   arr_t  m_rise, m_fall;
   arr_t  q_rise[$], q_fall[$];
   int    q_cyc[$], q_r0[$], q_f0[$];
   string q_name[$];

   task automatic check(input string name, input logic ok, input string detail);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic string arr_diff(input arr_t got, input arr_t exp);
      for (int i = 0; i < N; i++)
         if (got[i] !== exp[i])
            return $sformatf("entry %0d got %0d expected %0d", i, got[i], exp[i]);
      return "equal";
   endfunction

   task automatic model_edges(input int d, input int p, input int c, output int r, output int f);
      int dn, pn;
      if (c == 0) begin
         r = 0;
         f = 0;
         return;
      end
      dn = (d > c) ? c : d;
      pn = (p >= c) ? p - c : p;
      r  = (2 * c - pn - dn / 2) % c;
      f  = (c - pn + (dn + 1) / 2) % c;
   endtask

   // Drives n_valid elements; a complete frame queues its expected bank.
   task automatic send(input string name, input int n_valid, input int r0, input int f0,
                       input bit drop_valid);
      int r, f;
      for (int i = 0; i < n_valid; i++) begin
         @(posedge CLK);
         #1;
         bus.DIN_VALID = 1'b1;
         bus.DUTY      = W'(fd[i]);
         bus.PHASE     = W'(fp[i]);
         model_edges(fd[i], fp[i], int'(bus.CYCLE[i]), r, f);
         m_rise[i] = W'(r);
         m_fall[i] = W'(f);
         if (i == N - 1) begin
            q_rise.push_back(m_rise);
            q_fall.push_back(m_fall);
            q_cyc.push_back(cyc + 3);
            q_r0.push_back(r0);
            q_f0.push_back(f0);
            q_name.push_back(name);
         end
      end
      if (drop_valid) begin
         @(posedge CLK);
         #1;
         bus.DIN_VALID = 1'b0;
      end
   endtask

   task automatic directed(input string name, input int d0, input int p0, input int r0, input int f0);
      for (int i = 0; i < N; i++) begin
         fd[i] = 0;
         fp[i] = 0;
      end
      fd[0] = d0;
      fp[0] = p0;
      send(name, N, r0, f0, 1'b1);
   endtask

   // Monitor: every DOUT_VALID sample must match the oldest queued frame
   always @(negedge CLK) begin
      if (!RST && bus.DOUT_VALID === 1'b1) begin
         if (q_cyc.size() == 0) begin
            check("unexpected_pulse", 1'b0, $sformatf("DOUT_VALID high at cycle %0d, expected low", cyc));
         end else begin
            int    ecyc, r0, f0;
            arr_t  er, ef;
            string nm;
            ecyc = q_cyc.pop_front();
            er   = q_rise.pop_front();
            ef   = q_fall.pop_front();
            r0   = q_r0.pop_front();
            f0   = q_f0.pop_front();
            nm   = q_name.pop_front();
            check({nm, "_pulse_cycle"}, cyc == ecyc, $sformatf("pulse at cycle %0d, expected %0d", cyc, ecyc));
            check({nm, "_rise"}, bus.RISE === er, arr_diff(bus.RISE, er));
            check({nm, "_fall"}, bus.FALL === ef, arr_diff(bus.FALL, ef));
            if (r0 >= 0) begin
               check({nm, "_rise0"}, int'(bus.RISE[0]) == r0, $sformatf("got %0d expected %0d", bus.RISE[0], r0));
               check({nm, "_fall0"}, int'(bus.FALL[0]) == f0, $sformatf("got %0d expected %0d", bus.FALL[0], f0));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST           = 1'b1;
      bus.DIN_VALID = 1'b0;
      bus.DUTY      = '0;
      bus.PHASE     = '0;
      for (int i = 0; i < N; i++) bus.CYCLE[i] = W'(4096);
      m_rise = '0;
      m_fall = '0;
      #12;
      check("reset_rise", bus.RISE === '0, arr_diff(bus.RISE, '0));
      check("reset_fall", bus.FALL === '0, arr_diff(bus.FALL, '0));
      check("reset_dout_valid", bus.DOUT_VALID === 1'b0, $sformatf("got %b expected 0", bus.DOUT_VALID));
      #10 RST = 1'b0;

      directed("d2048_p2048", 2048, 2048, 1024, 3072);
      directed("d4096_p2048", 4096, 2048, 0, 0);
      directed("d0_p2048",    0,    2048, 2048, 2048);
      directed("d2048_p1024", 2048, 1024, 2048, 0);
      directed("d2048_p3072", 2048, 3072, 0, 2048);
      directed("d2048_p0",    2048, 0,    3072, 1024);
      directed("d2048_p4096", 2048, 4096, 3072, 1024);
      directed("d0_p4096",    0,    4096, 0, 0);
      directed("d1_p0",       1,    0,    0, 1);
      bus.CYCLE[0] = '0;
      directed("c0_zero", 2048, 2048, 0, 0);
      bus.CYCLE[0] = W'(4096);

      // Aborted frame: entries 0..99 update, no pulse
      fd[0] = 2048;
      fp[0] = 1024;
      send("abort", 100, -1, -1, 1'b1);
      repeat (5) @(posedge CLK);
      #1;
      check("abort_rise0", int'(bus.RISE[0]) == 2048, $sformatf("got %0d expected 2048", bus.RISE[0]));
      check("abort_fall0", int'(bus.FALL[0]) == 0, $sformatf("got %0d expected 0", bus.FALL[0]));
      check("abort_bank_rise", bus.RISE === m_rise, arr_diff(bus.RISE, m_rise));
      directed("after_abort", 2048, 2048, 1024, 3072);

      // Reset while DIN_VALID is still high
      fd[0] = 2048;
      fp[0] = 0;
      send("reset_mid", 50, -1, -1, 1'b0);
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      check("midreset_rise", bus.RISE === '0, arr_diff(bus.RISE, '0));
      check("midreset_fall", bus.FALL === '0, arr_diff(bus.FALL, '0));
      check("midreset_dout_valid", bus.DOUT_VALID === 1'b0, $sformatf("got %b expected 0", bus.DOUT_VALID));
      bus.DIN_VALID = 1'b0;
      m_rise = '0;
      m_fall = '0;
      @(posedge CLK);
      #3;
      RST = 1'b0;
      directed("after_reset", 2048, 2048, 1024, 3072);

      // Randomised frames against the integer model
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) begin
            int c;
            c            = int'($urandom_range(4096, 1));
            bus.CYCLE[i] = W'(c);
            fd[i]        = int'($urandom_range(c, 0));
            fp[i]        = int'($urandom_range(2 * c - 1, 0));
         end
         send($sformatf("rand%0d", k), N, -1, -1, 1'b1);
      end

      repeat (10) @(posedge CLK);
      #1;
      check("all_pulses_seen", q_cyc.size() == 0, $sformatf("%0d frames without pulse, expected 0", q_cyc.size()));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
